// File: rtl/card_deck_dealer_pkg.sv
// Shared defaults, LFSR polynomial and FSM encoding for the card deck dealer.
package card_deck_dealer_pkg;

    localparam int unsigned DEF_MAX_CARDS = 32;
    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_CNT_W     = 6;
    localparam int unsigned DEF_ID_W      = 4;

    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHUFFLE,
        ST_DONE
    } deal_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/card_deck_dealer_if.sv
// Options-screen/board side of the dealer: start request, status and deck read port.
interface card_deck_dealer_if #(
    parameter int unsigned ADDR_W = card_deck_dealer_pkg::DEF_ADDR_W,
    parameter int unsigned CNT_W  = card_deck_dealer_pkg::DEF_CNT_W,
    parameter int unsigned ID_W   = card_deck_dealer_pkg::DEF_ID_W
) ();

    logic              start;
    logic [CNT_W-1:0]  num_of_cards;
    logic [ADDR_W-1:0] rd_addr;
    logic [ID_W-1:0]   rd_data;
    logic [CNT_W-1:0]  deck_size;
    logic              busy;
    logic              done;

    modport master (
        output start, num_of_cards, rd_addr,
        input  rd_data, deck_size, busy, done
    );

    modport slave (
        input  start, num_of_cards, rd_addr,
        output rd_data, deck_size, busy, done
    );

endinterface

// File: rtl/card_deck_dealer_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle outside reset.
module lfsr16
    import card_deck_dealer_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_step(lfsr_q);
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/card_deck_dealer.sv
// Builds a deck of card pairs, shuffles it with Fisher-Yates driven by an LFSR,
// and serves it through a registered read port.
module card_deck_dealer
    import card_deck_dealer_pkg::*;
#(
    parameter int unsigned MAX_CARDS = DEF_MAX_CARDS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned ID_W      = DEF_ID_W,
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic                clk,
    input  logic                rst,
    card_deck_dealer_if.slave   bus
);

    deal_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   deck_q [MAX_CARDS];
    logic [ID_W-1:0]   rd_data_q;

    logic [15:0]       lfsr;
    logic              lfsr_unused;
    logic [ADDR_W-1:0] rnd;
    logic [CNT_W-1:0]  req_even, req_size;
    logic              last_fill, accept, idx_is_one;
    logic              fill_we, swap_we;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    assign rnd         = lfsr[ADDR_W-1:0];
    assign lfsr_unused = ^lfsr[15:ADDR_W];

    assign req_even   = bus.num_of_cards & ~CNT_W'(1);
    assign req_size   = (req_even == '0 || req_even > CNT_W'(MAX_CARDS)) ? CNT_W'(MAX_CARDS) : req_even;
    assign last_fill  = (CNT_W'(idx_q) == size_q - CNT_W'(1));
    assign accept     = (rnd <= idx_q);
    assign idx_is_one = (idx_q == ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_FILL;
            ST_FILL:          if (last_fill) state_d = ST_SHUFFLE;
            ST_SHUFFLE:       if (accept && idx_is_one) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        size_d  = size_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fill_we = 1'b0;
        swap_we = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    idx_d  = '0;
                    size_d = req_size;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            ST_FILL: begin
                fill_we = 1'b1;
                if (!last_fill) idx_d = idx_q + ADDR_W'(1);
            end
            ST_SHUFFLE: begin
                if (accept) begin
                    swap_we = 1'b1;
                    if (idx_is_one) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Swap writes both slots on the same edge; rnd == idx degenerates to a rewrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            size_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            for (int unsigned k = 0; k < MAX_CARDS; k++) deck_q[k] <= '0;
        end else begin
            idx_q     <= idx_d;
            size_q    <= size_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= deck_q[bus.rd_addr];
            if (fill_we) begin
                deck_q[idx_q] <= ID_W'(idx_q >> 1);
            end else if (swap_we) begin
                deck_q[idx_q] <= deck_q[rnd];
                deck_q[rnd]   <= deck_q[idx_q];
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.deck_size = size_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_card_deck_dealer.sv
// Scoreboard bench for card_deck_dealer: an algorithmic Fisher-Yates model predicts each deck.
module tb_card_deck_dealer;

    localparam int unsigned NMAX  = 32;
    localparam logic [1:0] K_DEAL  = 2'd0;
    localparam logic [1:0] K_ABORT = 2'd1;
    localparam logic [1:0] K_RESET = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [5:0]        n;
        logic [31:0]       start_cnt;
        logic [31:0]       done_cnt;
        logic [31:0][3:0]  deck;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_deck_dealer_if bus ();

    card_deck_dealer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t        exp_q[$];

    int unsigned cnt = 0;
    logic [15:0] m_lfsr = 16'h0;
    int unsigned m_deck [NMAX];
    logic [31:0][3:0] last_deck;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] mask;
        mask = (16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10);
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    function automatic int unsigned sanitize(input int unsigned num);
        int unsigned n;
        n = num - (num % 2);
        if (n == 0 || n > NMAX) n = NMAX;
        return n;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // cnt = edges since the last reset edge; m_lfsr = LFSR value present in the current cycle
    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 0;
            m_lfsr <= 16'hACE1;
        end else begin
            cnt    <= cnt + 1;
            m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    task automatic push_reset_item();
        exp_t e;
        e = '0;
        e.kind = K_RESET;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NMAX; k++) m_deck[k] = 0;
    endtask

    // Called on a negedge; predicts the deck from the LFSR value at the start edge.
    task automatic deal(input int unsigned num, input bit abort);
        exp_t e;
        int unsigned n, c, r, tmp;
        logic [15:0] l;
        n = sanitize(num);
        e = '0;
        e.kind = abort ? K_ABORT : K_DEAL;
        e.n = 6'(n);
        e.start_cnt = cnt + 1;
        for (int unsigned j = 0; j < n; j++) m_deck[j] = j / 2;
        l = m_lfsr;
        repeat (n + 1) l = lfsr_next(l);
        c = 0;
        for (int unsigned i = n - 1; i >= 1; i--) begin
            do begin
                r = 32'(l[4:0]);
                l = lfsr_next(l);
                c++;
            end while (r > i);
            tmp = m_deck[i];
            m_deck[i] = m_deck[r];
            m_deck[r] = tmp;
        end
        e.done_cnt = cnt + 1 + n + c;
        for (int j = 0; j < NMAX; j++) e.deck[j] = m_deck[j][3:0];
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.num_of_cards = 6'(num);
        @(negedge clk);
        bus.start = 1'b0;
        bus.num_of_cards = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_idle();
        int unsigned g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            check("scoreboard_drain", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: owns rd_addr, pops the head item when the DUT presents it
    initial begin : monitor
        exp_t e;
        int unsigned g;
        int unsigned got [NMAX];
        int unsigned tally [NMAX];
        int unsigned bad;
        bus.rd_addr = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (e.kind == K_RESET) begin
                    check("rst_busy", bus.busy, 0);
                    check("rst_done", bus.done, 0);
                    check("rst_deck_size", bus.deck_size, 0);
                    bus.rd_addr = '0;
                    for (int unsigned j = 0; j < NMAX; j++) begin
                        @(negedge clk);
                        check("rst_rd_data", bus.rd_data, 0);
                        bus.rd_addr = 5'(j + 1);
                    end
                end else begin
                    g = 0;
                    while (cnt != e.start_cnt && g < 10) begin
                        @(negedge clk);
                        g++;
                    end
                    check("start_timing", cnt, e.start_cnt);
                    check("busy_after_start", bus.busy, 1);
                    check("done_after_start", bus.done, 0);
                    check("deck_size", bus.deck_size, e.n);
                    @(negedge clk);
                    bus.rd_addr = '0;
                    for (int unsigned j = 0; j < e.n; j++) begin
                        @(negedge clk);
                        check("fill_value", bus.rd_data, j / 2);
                        bus.rd_addr = 5'(j + 1);
                    end
                    if (e.kind == K_DEAL) begin
                        g = 0;
                        while (!bus.done && g < 3000) begin
                            @(negedge clk);
                            g++;
                        end
                        check("done_seen", bus.done, 1);
                        check("done_cycle", cnt, e.done_cnt);
                        check("busy_at_done", bus.busy, 0);
                        check("deck_size_at_done", bus.deck_size, e.n);
                        bus.rd_addr = '0;
                        for (int unsigned j = 0; j < NMAX; j++) begin
                            @(negedge clk);
                            got[j] = bus.rd_data;
                            last_deck[j] = bus.rd_data;
                            check("deck_entry", got[j], e.deck[j]);
                            bus.rd_addr = 5'(j + 1);
                        end
                        for (int k = 0; k < NMAX; k++) tally[k] = 0;
                        for (int unsigned j = 0; j < e.n; j++) tally[got[j] % NMAX]++;
                        bad = 0;
                        for (int unsigned k = 0; k < NMAX; k++) begin
                            if (k < e.n / 2 && tally[k] != 2) bad++;
                            if (k >= e.n / 2 && tally[k] != 0) bad++;
                        end
                        check("pair_invariant_bad_ids", bad, 0);
                    end
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0][3:0] saved;
        int unsigned off;
        bus.start = 1'b0;
        bus.num_of_cards = '0;

        do_reset();
        push_reset_item();
        wait_idle();

        deal(16, 1'b0);
        wait_idle();

        deal(15, 1'b0);
        wait_idle();
        deal(0, 1'b0);
        wait_idle();
        deal(40, 1'b0);
        wait_idle();

        // Starts while busy must be ignored, both in FILL and in SHUFFLE
        deal(24, 1'b0);
        repeat (5) @(negedge clk);
        if (bus.busy) begin
            bus.start = 1'b1;
            bus.num_of_cards = 6'd8;
            @(negedge clk);
            bus.start = 1'b0;
        end
        repeat (22) @(negedge clk);
        if (bus.busy) begin
            bus.start = 1'b1;
            bus.num_of_cards = 6'd8;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle();

        // Reset in the middle of a shuffle
        deal(32, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk);
        check("busy_before_rst", bus.busy, 1);
        do_reset();
        push_reset_item();
        wait_idle();
        deal(20, 1'b0);
        wait_idle();

        // Same offset from reset reproduces the deck; another offset changes it
        off = $urandom_range(2, 20);
        do_reset();
        repeat (off) @(negedge clk);
        deal(32, 1'b0);
        wait_idle();
        saved = last_deck;
        do_reset();
        repeat (off) @(negedge clk);
        deal(32, 1'b0);
        wait_idle();
        check("same_offset_same_deck", (saved == last_deck) ? 1 : 0, 1);
        do_reset();
        repeat (off + 1) @(negedge clk);
        deal(32, 1'b0);
        wait_idle();
        check("other_offset_differs", (saved != last_deck) ? 1 : 0, 1);

        for (int t = 0; t < 5; t++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            deal($urandom_range(0, 63), 1'b0);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
